// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-refill / data-access memory arbiter.
package mem_arbiter_pkg;

    localparam int BLOCK_WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IFILL = 2'd1,
        DACC  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Requester a is the instruction side and owns the
// last grant after reset, so b wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic take_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic last_is_b_q;
    logic last_is_b_d;

    // On a tie the side that was not served last gets the grant.
    assign gnt_a_o = req_a_i & (~req_b_i | last_is_b_q);
    assign gnt_b_o = req_b_i & ~gnt_a_o;

    always_comb begin
        last_is_b_d = last_is_b_q;
        if (take_i) begin
            last_is_b_d = gnt_b_o;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_is_b_q <= 1'b0;
        end else begin
            last_is_b_q <= last_is_b_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache line refills and data accesses.
// Request outputs are registered; done/refill strobes are combinational on mready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           imiss,
    input  logic [31:0]                    imissaddr,
    input  logic                           dreq,
    input  logic                           dwe,
    input  logic [31:0]                    daddr,
    input  logic [31:0]                    dwdata,
    input  logic                           mready,
    input  logic [31:0]                    mrdata,
    output logic                           mreq,
    output logic                           mwe,
    output logic [31:0]                    maddr,
    output logic [31:0]                    mwdata,
    output logic                           irefill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] irefill_word,
    output logic [31:0]                    irefill_data,
    output logic                           irefill_done,
    output logic                           ddone,
    output logic [31:0]                    drdata,
    output logic                           stall_i,
    output logic                           stall_d
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic [IDX_W-1:0]  beat_nxt;
    logic              mreq_q, mreq_d;
    logic              mwe_q, mwe_d;
    logic [31:0]       maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [31:0]       drdata_q, drdata_d;
    logic              gnt_i, gnt_d;
    logic              take;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{imissaddr[IDX_W+1:0], daddr[1:0]};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req_a_i (imiss),
        .req_b_i (dreq),
        .take_i  (take),
        .gnt_a_o (gnt_i),
        .gnt_b_o (gnt_d)
    );

    assign beat_nxt = beat_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        mreq_d       = mreq_q;
        mwe_d        = mwe_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        drdata_d     = drdata_q;
        take         = 1'b0;
        irefill_we   = 1'b0;
        irefill_done = 1'b0;
        ddone        = 1'b0;
        unique case (state_q)
            IDLE: begin
                take = imiss | dreq;
                if (gnt_i) begin
                    state_d  = IFILL;
                    beat_d   = '0;
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b0;
                    maddr_d  = {imissaddr[31:IDX_W+2], {IDX_W{1'b0}}, 2'b00};
                    mwdata_d = '0;
                end else if (gnt_d) begin
                    state_d  = DACC;
                    mreq_d   = 1'b1;
                    mwe_d    = dwe;
                    maddr_d  = {daddr[31:2], 2'b00};
                    mwdata_d = dwdata;
                end
            end
            IFILL: begin
                // Line base is taken from maddr_q so a dropped imiss cannot disturb the refill.
                if (mready) begin
                    irefill_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        irefill_done = 1'b1;
                        state_d      = IDLE;
                        mreq_d       = 1'b0;
                        beat_d       = '0;
                    end else begin
                        beat_d  = beat_nxt;
                        maddr_d = {maddr_q[31:IDX_W+2], beat_nxt, 2'b00};
                    end
                end
            end
            DACC: begin
                if (mready) begin
                    ddone   = 1'b1;
                    state_d = IDLE;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    if (!mwe_q) begin
                        drdata_d = mrdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mreq_d  = 1'b0;
                mwe_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign mreq         = mreq_q;
    assign mwe          = mwe_q;
    assign maddr        = maddr_q;
    assign mwdata       = mwdata_q;
    assign drdata       = drdata_q;
    assign irefill_word = beat_q;
    assign irefill_data = irefill_we ? mrdata : 32'd0;
    assign stall_i      = imiss & ~irefill_done;
    assign stall_d      = dreq & ~ddone;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed sequences, a grant table and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int BW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imiss = 1'b0, dreq = 1'b0, dwe = 1'b0, mready = 1'b0;
    logic [31:0]   imissaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
    logic          mreq, mwe, irefill_we, irefill_done, ddone, stall_i, stall_d;
    logic [31:0]   maddr, mwdata, irefill_data, drdata;
    logic [IW-1:0] irefill_word;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_drdata = '0;

    mem_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .reset(reset), .imiss(imiss), .imissaddr(imissaddr),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .mready(mready), .mrdata(mrdata), .mreq(mreq), .mwe(mwe),
        .maddr(maddr), .mwdata(mwdata), .irefill_we(irefill_we),
        .irefill_word(irefill_word), .irefill_data(irefill_data),
        .irefill_done(irefill_done), .ddone(ddone), .drdata(drdata),
        .stall_i(stall_i), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        imiss = 0; dreq = 0; dwe = 0; mready = 0;
        imissaddr = '0; daddr = '0; dwdata = '0; mrdata = '0;
        @(negedge clk);
        chk("rst_mreq", 32'(mreq), 0);
        chk("rst_mwe", 32'(mwe), 0);
        chk("rst_maddr", maddr, 0);
        chk("rst_mwdata", mwdata, 0);
        chk("rst_irefill_we", 32'(irefill_we), 0);
        chk("rst_irefill_word", 32'(irefill_word), 0);
        chk("rst_irefill_data", irefill_data, 0);
        chk("rst_irefill_done", 32'(irefill_done), 0);
        chk("rst_ddone", 32'(ddone), 0);
        chk("rst_drdata", drdata, 0);
        chk("rst_stall_i", 32'(stall_i), 0);
        chk("rst_stall_d", 32'(stall_d), 0);
        tick();
        reset = 1'b0;
        exp_drdata = '0;
    endtask

    // Full line refill with mready every cycle; optionally drop imiss at beat drop_beat.
    task automatic fill_seq(input logic [31:0] a, input int drop_beat);
        logic [31:0] base;
        base = a & ~32'(BW * 4 - 1);
        tick();
        imiss = 1; imissaddr = a; dreq = 0; mready = 1; mrdata = 32'h5555_0000;
        @(negedge clk);
        chk("fill_idle_mreq", 32'(mreq), 0);
        chk("fill_idle_we", 32'(irefill_we), 0);
        for (int b = 0; b < BW; b++) begin
            tick();
            mrdata = 32'hA000_0000 + 32'(b) * 32'h11;
            if (b == drop_beat) imiss = 0;
            @(negedge clk);
            chk("fill_mreq", 32'(mreq), 1);
            chk("fill_maddr", maddr, base + 32'(4 * b));
            chk("fill_mwe", 32'(mwe), 0);
            chk("fill_we", 32'(irefill_we), 1);
            chk("fill_word", 32'(irefill_word), 32'(b));
            chk("fill_data", irefill_data, 32'hA000_0000 + 32'(b) * 32'h11);
            chk("fill_done", 32'(irefill_done), 32'(b == BW - 1));
            chk("fill_stall_i", 32'(stall_i), 32'(imiss && (b != BW - 1)));
        end
        tick();
        imiss = 0; mready = 0;
        @(negedge clk);
        chk("fill_after_mreq", 32'(mreq), 0);
        chk("fill_after_done", 32'(irefill_done), 0);
    endtask

    task automatic data_seq(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd);
        logic [31:0] old_dr;
        old_dr = exp_drdata;
        tick();
        dreq = 1; dwe = we; daddr = a; dwdata = wd; mready = 0;
        @(negedge clk);
        chk("dacc_idle_mreq", 32'(mreq), 0);
        chk("dacc_idle_stall_d", 32'(stall_d), 1);
        for (int w = 0; w <= waits; w++) begin
            tick();
            mready = (w == waits);
            mrdata = (w == waits) ? rd : 32'hBAD0_0000 + 32'(w);
            @(negedge clk);
            chk("dacc_mreq", 32'(mreq), 1);
            chk("dacc_maddr", maddr, {a[31:2], 2'b00});
            chk("dacc_mwe", 32'(mwe), 32'(we));
            if (we) chk("dacc_mwdata", mwdata, wd);
            chk("dacc_ddone", 32'(ddone), 32'(w == waits));
            chk("dacc_stall_d", 32'(stall_d), 32'(w != waits));
            chk("dacc_drdata_hold", drdata, old_dr);
        end
        if (!we) exp_drdata = rd;
        tick();
        dreq = 0; mready = 0;
        @(negedge clk);
        chk("dacc_after_mreq", 32'(mreq), 0);
        chk("dacc_after_ddone", 32'(ddone), 0);
        chk("dacc_after_drdata", drdata, exp_drdata);
        chk("dacc_after_stall_d", 32'(stall_d), 0);
    endtask

    typedef struct {
        logic        i;
        logic        d;
        logic        we;
        logic [31:0] ia;
        logic [31:0] da;
        logic        exp_fill;
        logic [31:0] exp_addr;
        logic        exp_we;
    } vec_t;

    vec_t vecs[8];

    // Reference model state (transaction level)
    int          m_act;      // 0 none, 1 refill, 2 data
    int          m_beat;
    logic        m_last_d;
    logic [31:0] m_base, m_daddr, m_dwdata, m_drdata;
    logic        m_dwe;

    initial begin
        bit seen;
        logic drop_i, drop_d, e_we, e_idone, e_ddone;
        int   prev_act;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0120, 32'h0000_2004, 1'b0, 32'h0000_2004, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0120, 32'h0000_2004, 1'b1, 32'h0000_0120, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h3000_000B, 1'b0, 32'h3000_0008, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_FFFC, 32'h0000_0000, 1'b1, 32'h0000_FFF0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0044, 1'b0, 32'h0000_0044, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0010, 1'b0, 32'h0000_0010, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0300, 1'b1, 32'h0000_0200, 1'b0};

        reset_dut();

        // Tie straight after reset: data first, then a second tie goes to instruction.
        tick();
        imiss = 1; imissaddr = 32'h0000_0A04; dreq = 1; dwe = 0; daddr = 32'h0000_0B00;
        mready = 1; mrdata = 32'h1111_2222;
        @(negedge clk);
        chk("tie_idle_mreq", 32'(mreq), 0);
        tick();
        @(negedge clk);
        chk("tie1_maddr", maddr, 32'h0000_0B00);
        chk("tie1_ddone", 32'(ddone), 1);
        chk("tie1_we", 32'(irefill_we), 0);
        tick();
        daddr = 32'h0000_0C00;
        @(negedge clk);
        chk("tie_gap_mreq", 32'(mreq), 0);
        chk("tie_gap_drdata", drdata, 32'h1111_2222);
        tick();
        @(negedge clk);
        chk("tie2_maddr", maddr, 32'h0000_0A00);
        chk("tie2_fill", 32'(irefill_we), 1);
        tick();
        dreq = 0;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (irefill_done) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("tie2_fill_done", 32'(seen), 1);
        tick();
        imiss = 0; mready = 0;

        reset_dut();
        fill_seq(32'h0040_0014, -1);
        data_seq(32'h1000_0008, 1'b0, 32'h0, 3, 32'hDEAD_BEEF);
        data_seq(32'h2000_0010, 1'b1, 32'h1234_5678, 1, 32'hFFFF_0000);
        fill_seq(32'h0000_3338, 1);

        // Reset in the middle of a refill, then a fresh miss restarts at beat 0.
        tick();
        imiss = 1; imissaddr = 32'h0000_7008; mready = 1;
        @(negedge clk);
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        chk("rstmid_beat1_maddr", maddr, 32'h0000_7004);
        tick();
        mready = 0;
        #1;
        chk("rstmid_beat2_maddr", maddr, 32'h0000_7008);
        chk("rstmid_beat2_mreq", 32'(mreq), 1);
        reset = 1;
        imiss = 0;
        #1;
        chk("rstmid_mreq_async", 32'(mreq), 0);
        chk("rstmid_no_done", 32'(irefill_done), 0);
        #1;
        reset = 0;
        exp_drdata = '0;
        fill_seq(32'h0000_7008, -1);

        reset_dut();
        for (int v = 0; v < 8; v++) begin
            tick();
            imiss = vecs[v].i; dreq = vecs[v].d; dwe = vecs[v].we;
            imissaddr = vecs[v].ia; daddr = vecs[v].da; dwdata = 32'hC0DE_0000 + 32'(v);
            mready = 1; mrdata = 32'h7700_0000 + 32'(v);
            @(negedge clk);
            chk("vec_idle_mreq", 32'(mreq), 0);
            tick();
            @(negedge clk);
            chk("vec_mreq", 32'(mreq), 1);
            chk("vec_maddr", maddr, vecs[v].exp_addr);
            chk("vec_mwe", 32'(mwe), 32'(vecs[v].exp_we));
            chk("vec_fill", 32'(irefill_we), 32'(vecs[v].exp_fill));
            chk("vec_ddone", 32'(ddone), 32'(!vecs[v].exp_fill));
            if (vecs[v].exp_fill) begin
                tick();
                dreq = 0;
                seen = 0;
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    if (irefill_done) begin
                        seen = 1;
                        break;
                    end
                    tick();
                end
                chk("vec_fill_done", 32'(seen), 1);
            end
            tick();
            imiss = 0; dreq = 0; mready = 0;
        end

        // Randomized run against the transaction-level model.
        reset_dut();
        m_act = 0; m_beat = 0; m_last_d = 0; m_drdata = '0;
        m_base = '0; m_daddr = '0; m_dwdata = '0; m_dwe = 0;
        drop_i = 0; drop_d = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (drop_i) imiss = 0;
            if (drop_d) dreq = 0;
            if (!imiss && !drop_i && $urandom_range(0, 3) == 0) begin
                imiss = 1; imissaddr = $urandom;
            end
            if (!dreq && !drop_d && $urandom_range(0, 3) == 0) begin
                dreq = 1; dwe = 1'($urandom_range(0, 1)); daddr = $urandom; dwdata = $urandom;
            end
            drop_i = 0; drop_d = 0;
            mready = ($urandom_range(0, 2) == 0);
            mrdata = $urandom;
            @(negedge clk);
            e_we    = (m_act == 1) && mready;
            e_idone = e_we && (m_beat == BW - 1);
            e_ddone = (m_act == 2) && mready;
            chk("rnd_mreq", 32'(mreq), 32'(m_act != 0));
            if (m_act == 1) begin
                chk("rnd_fill_maddr", maddr, m_base + 32'(4 * m_beat));
                chk("rnd_fill_mwe", 32'(mwe), 0);
            end
            if (m_act == 2) begin
                chk("rnd_dacc_maddr", maddr, {m_daddr[31:2], 2'b00});
                chk("rnd_dacc_mwe", 32'(mwe), 32'(m_dwe));
                if (m_dwe) chk("rnd_dacc_mwdata", mwdata, m_dwdata);
            end
            chk("rnd_irefill_we", 32'(irefill_we), 32'(e_we));
            chk("rnd_irefill_done", 32'(irefill_done), 32'(e_idone));
            chk("rnd_ddone", 32'(ddone), 32'(e_ddone));
            if (e_we) begin
                chk("rnd_irefill_word", 32'(irefill_word), 32'(m_beat));
                chk("rnd_irefill_data", irefill_data, mrdata);
            end
            chk("rnd_drdata", drdata, m_drdata);
            chk("rnd_stall_i", 32'(stall_i), 32'(imiss && !e_idone));
            chk("rnd_stall_d", 32'(stall_d), 32'(dreq && !e_ddone));

            prev_act = m_act;
            if (prev_act == 1 && mready) begin
                if (m_beat == BW - 1) begin
                    m_act = 0;
                    drop_i = 1;
                end else begin
                    m_beat++;
                end
            end else if (prev_act == 2 && mready) begin
                if (!m_dwe) m_drdata = mrdata;
                m_act = 0;
                drop_d = 1;
            end else if (prev_act == 0 && (imiss || dreq)) begin
                if (imiss && (!dreq || m_last_d)) begin
                    m_act = 1;
                    m_beat = 0;
                    m_base = imissaddr & ~32'(BW * 4 - 1);
                    m_last_d = 0;
                end else begin
                    m_act = 2;
                    m_daddr = daddr; m_dwe = dwe; m_dwdata = dwdata;
                    m_last_d = 1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
